ins_mem_loadable: RTL and testbench

- Parametrised, writable instruction memory for the CPU fetch path.
- A sequential loader FSM streams a program into the array from address 0 upward.
- After loading, the memory serves fetch requests with a registered read of one cycle latency and a valid flag.
- Fetches are refused until a complete program has been loaded.

---
 rtl/ins_mem_loadable.sv | 114 +++++++++++
 tb/tb_ins_mem_loadable.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loadable.sv
// Loadable instruction memory: a loader FSM fills the array from address 0 upward,
// after which fetches are served with a registered one-cycle read.
module ins_mem_loadable #(
  parameter int word_size  = 8,
  parameter int index_size = 4,
  parameter int num_ins    = 2 ** index_size
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [word_size-1:0]  load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [index_size:0]   load_count,
  input  logic                  fetch_req,
  input  logic [index_size-1:0] prog_count,
  output logic [word_size-1:0]  ins_val,
  output logic                  ins_valid,
  output logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [index_size:0] last_count = (index_size + 1)'(num_ins - 1);
  localparam logic [index_size:0] count_one  = (index_size + 1)'(1);

  state_t                  state_reg;
  logic [word_size-1:0]    mem_reg [num_ins];
  logic [index_size:0]     load_count_reg;
  logic [word_size-1:0]    ins_val_reg;
  logic                    ins_valid_reg;
  logic                    load_ready_reg;
  logic                    load_done_reg;
  logic                    mem_ready_reg;
  logic                    accept;
  logic [index_size-1:0]   wr_addr;

  // A restart in the same cycle as a valid word discards that word.
  assign accept  = (state_reg == LOAD) && load_valid && !load_start;
  assign wr_addr = load_count_reg[index_size-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_ins; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (accept) begin
      mem_reg[wr_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      load_count_reg <= '0;
      ins_val_reg    <= '0;
      ins_valid_reg  <= 1'b0;
      load_ready_reg <= 1'b0;
      load_done_reg  <= 1'b0;
      mem_ready_reg  <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      ins_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            state_reg      <= LOAD;
            load_count_reg <= '0;
            load_ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            load_count_reg <= '0;
          end else if (load_valid) begin
            load_count_reg <= load_count_reg + count_one;
            // Count stops at num_ins because the loader leaves LOAD here.
            if (load_count_reg == last_count) begin
              state_reg      <= RUN;
              load_done_reg  <= 1'b1;
              load_ready_reg <= 1'b0;
              mem_ready_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state_reg      <= LOAD;
            load_count_reg <= '0;
            load_ready_reg <= 1'b1;
            mem_ready_reg  <= 1'b0;
          end else if (fetch_req) begin
            ins_val_reg   <= mem_reg[prog_count];
            ins_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          load_ready_reg <= 1'b0;
          mem_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = load_ready_reg;
  assign load_done  = load_done_reg;
  assign load_count = load_count_reg;
  assign ins_val    = ins_val_reg;
  assign ins_valid  = ins_valid_reg;
  assign mem_ready  = mem_ready_reg;

endmodule

// File: tb/tb_ins_mem_loadable.sv
// Scenario bench for ins_mem_loadable: loads programs, restarts, resets mid-load
// and fetches through a scoreboard queue of expected instruction words.
module tb_ins_mem_loadable;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       load_done;
  logic [4:0] load_count;
  logic       fetch_req;
  logic [3:0] prog_count;
  logic [7:0] ins_val;
  logic       ins_valid;
  logic       mem_ready;

  int         vec_count;
  int         miscompares;
  logic [7:0] model_mem [16];
  logic [7:0] exp_q [$];
  logic [3:0] fetch_addrs [$];
  logic [7:0] last_val;

  ins_mem_loadable #(.word_size(8), .index_size(4), .num_ins(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .fetch_req  (fetch_req),
    .prog_count (prog_count),
    .ins_val    (ins_val),
    .ins_valid  (ins_valid),
    .mem_ready  (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; load_data = '0; load_valid = 1'b0;
    fetch_req = 1'b0; prog_count = '0;
    repeat (2) tick();
    vec_count++;
    if ({ins_val, ins_valid, load_ready, load_done, load_count, mem_ready} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got val=%0h v=%0b rdy=%0b done=%0b cnt=%0d mrdy=%0b, expected all zero",
               ins_val, ins_valid, load_ready, load_done, load_count, mem_ready);
    end
    rst_n = 1'b1;
    fetch_req = 1'b1; prog_count = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_count++;
      if (ins_valid !== 1'b0 || ins_val !== 8'h00 || mem_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_fetch: got v=%0b val=%0h mrdy=%0b, expected v=0 val=00 mrdy=0",
                 ins_valid, ins_val, mem_ready);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load_sequential(input logic [7:0] base);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    vec_count++;
    if (load_ready !== 1'b1 || load_count !== 5'd0 || mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_enter: got rdy=%0b cnt=%0d mrdy=%0b, expected rdy=1 cnt=0 mrdy=0",
               load_ready, load_count, mem_ready);
    end
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(i);
      model_mem[i] = base + 8'(i);
      tick();
      vec_count++;
      if (i < 15) begin
        if (load_ready !== 1'b1 || load_done !== 1'b0 || load_count !== 5'(i + 1)) begin
          miscompares++;
          $display("FAIL load_stream[%0d]: got rdy=%0b done=%0b cnt=%0d, expected rdy=1 done=0 cnt=%0d",
                   i, load_ready, load_done, load_count, i + 1);
        end
      end else begin
        if (load_done !== 1'b1 || load_count !== 5'd16 || mem_ready !== 1'b1 || load_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL load_last: got done=%0b cnt=%0d mrdy=%0b rdy=%0b, expected done=1 cnt=16 mrdy=1 rdy=0",
                   load_done, load_count, mem_ready, load_ready);
        end
      end
    end
    load_valid = 1'b0;
    tick();
    vec_count++;
    if (load_done !== 1'b0 || load_count !== 5'd16 || mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_after: got done=%0b cnt=%0d mrdy=%0b, expected done=0 cnt=16 mrdy=1",
               load_done, load_count, mem_ready);
    end
  endtask

  task automatic test_fetch_burst();
    logic [7:0] exp_val;
    while (fetch_addrs.size() > 0) begin
      prog_count = fetch_addrs.pop_front();
      fetch_req  = 1'b1;
      exp_q.push_back(model_mem[prog_count]);
      tick();
      vec_count++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fetch_queue: got empty scoreboard, expected a pending word");
      end else begin
        exp_val = exp_q.pop_front();
        last_val = exp_val;
        if (ins_valid !== 1'b1 || ins_val !== exp_val) begin
          miscompares++;
          $display("FAIL fetch_data: got v=%0b val=%0h, expected v=1 val=%0h", ins_valid, ins_val, exp_val);
        end
      end
    end
    fetch_req = 1'b0;
    tick();
    vec_count++;
    if (ins_valid !== 1'b0 || ins_val !== last_val) begin
      miscompares++;
      $display("FAIL fetch_hold: got v=%0b val=%0h, expected v=0 val=%0h", ins_valid, ins_val, last_val);
    end
  endtask

  task automatic test_restart();
    int accepted;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    accepted = 0;
    for (int c = 0; accepted < 7 && c < 40; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = 8'h30 + 8'(accepted);
      tick();
      if (load_valid) accepted++;
    end
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
    tick();
    load_start = 1'b0;
    vec_count++;
    if (load_count !== 5'd0 || load_ready !== 1'b1 || load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_clear: got cnt=%0d rdy=%0b done=%0b, expected cnt=0 rdy=1 done=0",
               load_count, load_ready, load_done);
    end
    accepted = 0;
    for (int c = 0; c < 31; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = 8'h40 + 8'(accepted);
      if (load_valid) model_mem[accepted] = load_data;
      tick();
      if (load_valid) accepted++;
      vec_count++;
      if (load_count !== 5'(accepted) || load_done !== (load_valid && accepted == 16)) begin
        miscompares++;
        $display("FAIL restart_stream[%0d]: got cnt=%0d done=%0b, expected cnt=%0d done=%0b",
                 c, load_count, load_done, accepted, (load_valid && accepted == 16));
      end
    end
    load_valid = 1'b0;
    vec_count++;
    if (mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_run: got mrdy=%0b, expected 1", mem_ready);
    end
  endtask

  task automatic test_start_priority();
    load_start = 1'b1; fetch_req = 1'b1; prog_count = 4'd2;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    vec_count++;
    if (ins_valid !== 1'b0 || mem_ready !== 1'b0 || load_ready !== 1'b1 || load_count !== 5'd0) begin
      miscompares++;
      $display("FAIL start_priority: got v=%0b mrdy=%0b rdy=%0b cnt=%0d, expected v=0 mrdy=0 rdy=1 cnt=0",
               ins_valid, mem_ready, load_ready, load_count);
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h50 + 8'(i);
      tick();
    end
    load_valid = 1'b0;
    vec_count++;
    if (load_count !== 5'd9) begin
      miscompares++;
      $display("FAIL midload_count: got cnt=%0d, expected 9", load_count);
    end
    rst_n = 1'b0;
    #1;
    vec_count++;
    if ({ins_val, ins_valid, load_ready, load_done, load_count, mem_ready} !== 18'd0) begin
      miscompares++;
      $display("FAIL midload_reset: got val=%0h v=%0b rdy=%0b done=%0b cnt=%0d mrdy=%0b, expected all zero",
               ins_val, ins_valid, load_ready, load_done, load_count, mem_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    fetch_req = 1'b1; prog_count = 4'd2;
    tick();
    fetch_req = 1'b0;
    vec_count++;
    if (ins_valid !== 1'b0 || mem_ready !== 1'b0 || load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got v=%0b mrdy=%0b rdy=%0b, expected 0 0 0",
               ins_valid, mem_ready, load_ready);
    end
    test_load_sequential(8'hA0);
    fetch_addrs.push_back(4'd2);
    test_fetch_burst();
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    last_val    = 8'h00;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    test_reset();
    test_load_sequential(8'h10);
    fetch_addrs.push_back(4'd0);
    fetch_addrs.push_back(4'd5);
    fetch_addrs.push_back(4'd15);
    test_fetch_burst();
    test_restart();
    for (int i = 0; i < 16; i++) fetch_addrs.push_back(4'(i));
    test_fetch_burst();
    test_start_priority();
    test_reset_midload();
    vec_count++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
